ws2812_frame_ctrl: RTL and testbench
====================================

WS2812_FRAME_CTRL -- requirements
Module: ws2812_frame_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 8: number of pixels in the chain.
REQ-002 The block SHALL have parameter FRAME_CYCLES, default 800000: frame period in clk cycles (60 Hz at 48 MHz).
REQ-003 The block SHALL have parameter LATCH_CYCLES, default 4800: driver reset/latch hold in clk cycles (100 us at 48 MHz).
REQ-004 The block SHALL have these ports:
  clk  in  1  system clock, all logic on rising edge.
  reset  in  1  asynchronous, active-high reset.
  enable  in  1  frame generation on when high.
  wr_valid  in  1  host pixel write request.
  wr_ready  out  1  host write accepted when wr_valid and wr_ready are both high.
  wr_addr  in  $clog2(NUM_LEDS)  pixel index.
  wr_rgb  in  24  {red, green, blue}.
  commit  in  1  pulse: request a back/front bank swap.
  commit_pending  out  1  swap requested, not yet performed.
  frame_start  out  1  one-cycle pulse on entry to LATCH.
  drv_reset  out  1  reset to the WS2812 driver.
  drv_address  in  $clog2(NUM_LEDS)  pixel index requested by the driver.
  drv_new_address  in  1  driver strobe: drv_address is valid.
  red_out, green_out, blue_out  out  8 each  colour for the last requested pixel.

Function
REQ-005 The block SHALL have FSM states HOLD, LATCH and RUN.
REQ-006 HOLD SHALL drive drv_reset=1 and move to LATCH when enable=1.
REQ-007 LATCH SHALL drive drv_reset=1 for exactly LATCH_CYCLES cycles, then move to RUN.
REQ-008 RUN SHALL drive drv_reset=0 for exactly FRAME_CYCLES-LATCH_CYCLES cycles; at the end it SHALL move to LATCH if enable=1, else to HOLD.
REQ-009 In steady state, LATCH entries SHALL be exactly FRAME_CYCLES apart.
REQ-010 Deasserting enable mid-RUN SHALL NOT shorten the current frame.
REQ-011 frame_start SHALL pulse high for one cycle on every cycle that the FSM enters LATCH.
REQ-012 The block SHALL hold two banks of NUM_LEDS x 24-bit pixels: a front bank read by the driver and a back bank written by the host.
REQ-013 wr_ready SHALL equal !commit_pending.
REQ-014 An accepted write SHALL update the back bank at wr_addr on the next edge.
REQ-015 An accepted write with wr_addr >= NUM_LEDS SHALL be consumed and discarded.
REQ-016 commit SHALL set commit_pending; commit while commit_pending is already high SHALL have no further effect.
REQ-017 When the FSM enters LATCH with commit_pending=1, the block SHALL swap the bank roles on that edge and clear commit_pending.
REQ-018 Bank contents SHALL NOT be copied on a swap; the new back bank holds the previous front data.
REQ-019 commit in the same cycle as a swap SHALL be kept pending for the next LATCH entry.
REQ-020 wr_valid and commit in the same cycle SHALL accept the write, and the write SHALL be included in the swap.
REQ-021 On drv_new_address, red_out/green_out/blue_out SHALL present the front-bank entry at drv_address on the next cycle (latency 1), registered and held until the next strobe.
REQ-022 A driver strobe with drv_address >= NUM_LEDS SHALL output 0.
REQ-023 A swap SHALL NOT change the colour outputs until the next driver strobe.

Reset
REQ-024 Asserting reset SHALL force, asynchronously: state=HOLD, drv_reset=1, cycle counter=0, commit_pending=0, front=bank0, red/green/blue_out=0, frame_start=0, and all pixels in both banks=0.
REQ-025 On the first edge after reset is released, wr_ready SHALL be 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame and discard any pending commit.

Structure
REQ-027 Package ws2812_pkg SHALL hold the 24-bit rgb type, the FSM state enum, and the default FRAME_CYCLES/LATCH_CYCLES constants at 48 MHz.
REQ-028 The dual-bank storage SHALL be one sub-module, pixel_banks: one write port, one read port, and a bank-select input; the FSM and commit logic SHALL live in the top.

Verification (bench parameters FRAME_CYCLES=200, LATCH_CYCLES=20)
REQ-029 Reset released, enable=1 -> drv_reset high cycles 1-20, low for 180 cycles, frame_start pulses 200 cycles apart.
REQ-030 Write addr3=0xFF0000, commit mid-RUN -> commit_pending=1 and wr_ready=0 until next LATCH entry; afterwards a strobe at addr3 gives red_out=0xFF, green_out=0, blue_out=0 one cycle later.
REQ-031 Write addr3=0x00FF00 without commit -> driver still reads 0x000000 at addr3 after 3 frames.
REQ-032 commit coincident with LATCH entry (already pending) -> first swap taken, commit_pending stays 1, second swap one frame later.
REQ-033 enable dropped at RUN cycle 50 -> RUN completes its 180 cycles, FSM enters HOLD, drv_reset=1, no frame_start.
REQ-034 reset pulsed mid-RUN with commit pending -> all outputs return to reset values immediately, commit_pending=0, pixels read back 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: rgb pixel type, frame FSM states and 48 MHz timing defaults for ws2812_frame_ctrl
package ws2812_pkg;
  typedef logic [23:0] rgb_t;
  typedef enum logic [1:0] {HOLD, LATCH, RUN} state_t;
  localparam int FRAME_CYCLES_48M = 800000;
  localparam int LATCH_CYCLES_48M = 4800;
endpackage

// File: rtl/pixel_banks.sv
// pixel_banks: two NUM_LEDS x rgb banks; ports clk/reset, front_sel picks the read bank, we/waddr/wdata write the other bank, re/raddr give rdata one cycle later (0 when out of range)
module pixel_banks import ws2812_pkg::*; #(
  parameter int NUM_LEDS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        front_sel,
  input  logic                        we,
  input  logic [$clog2(NUM_LEDS)-1:0] waddr,
  input  rgb_t                        wdata,
  input  logic                        re,
  input  logic [$clog2(NUM_LEDS)-1:0] raddr,
  output rgb_t                        rdata
);
  localparam int AW = $clog2(NUM_LEDS);
  localparam logic [AW:0] N = (AW+1)'(NUM_LEDS);
  rgb_t mem [2][NUM_LEDS];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NUM_LEDS; i++)
          mem[b][i] <= '0;
      rdata <= '0;
    end else begin
      if (we && {1'b0, waddr} < N) mem[~front_sel][waddr] <= wdata;
      if (re) rdata <= {1'b0, raddr} < N ? mem[front_sel][raddr] : '0;
    end
endmodule

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: HOLD/LATCH/RUN frame timer driving drv_reset/frame_start, host write port + commit into a double-buffered pixel store read by the WS2812 driver
module ws2812_frame_ctrl import ws2812_pkg::*; #(
  parameter int NUM_LEDS     = 8,
  parameter int FRAME_CYCLES = FRAME_CYCLES_48M,
  parameter int LATCH_CYCLES = LATCH_CYCLES_48M
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [$clog2(NUM_LEDS)-1:0] wr_addr,
  input  rgb_t                        wr_rgb,
  input  logic                        commit,
  output logic                        commit_pending,
  output logic                        frame_start,
  output logic                        drv_reset,
  input  logic [$clog2(NUM_LEDS)-1:0] drv_address,
  input  logic                        drv_new_address,
  output logic [7:0]                  red_out,
  output logic [7:0]                  green_out,
  output logic [7:0]                  blue_out
);
  localparam int CW = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(FRAME_CYCLES - LATCH_CYCLES - 1);
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic front_sel, enter_latch, swap;
  rgb_t rgb;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= HOLD;
      cnt <= '0;
      commit_pending <= 1'b0;
      front_sel <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      commit_pending <= swap ? commit : commit_pending | commit;
      front_sel <= front_sel ^ swap;
      frame_start <= enter_latch;
    end
  always_comb begin
    nxt = state == HOLD  ? (enable ? LATCH : HOLD)
        : state == LATCH ? (cnt == LATCH_LAST ? RUN : LATCH)
        : cnt == RUN_LAST ? (enable ? LATCH : HOLD) : RUN;
    cnt_nxt = (nxt != state || state == HOLD) ? '0 : cnt + CW'(1);
    enter_latch = nxt == LATCH && state != LATCH;
    // a commit arriving on the swap edge survives for the next frame
    swap = enter_latch && commit_pending;
  end
  assign drv_reset = state != RUN;
  assign wr_ready = !commit_pending;
  assign {red_out, green_out, blue_out} = rgb;
  pixel_banks #(.NUM_LEDS(NUM_LEDS)) u_banks (
    .clk(clk),
    .reset(reset),
    .front_sel(front_sel),
    .we(wr_valid && wr_ready),
    .waddr(wr_addr),
    .wdata(wr_rgb),
    .re(drv_new_address),
    .raddr(drv_address),
    .rdata(rgb)
  );
endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb_ws2812_frame_ctrl: directed bench with a frame-age/array-swap reference model checked every cycle
module tb_ws2812_frame_ctrl;
  localparam int N = 6, FC = 200, LC = 20;
  logic clk = 0, reset = 1, enable = 0, wr_valid = 0, commit = 0, drv_new_address = 0;
  logic [2:0] wr_addr = 0, drv_address = 0;
  logic [23:0] wr_rgb = 0;
  logic wr_ready, commit_pending, frame_start, drv_reset;
  logic [7:0] red_out, green_out, blue_out;
  int checks = 0, passed = 0;
  int age, n_hi, n_fs;
  bit m_pend, m_fs, enter;
  logic [23:0] m_front[N], m_back[N], m_rgb, tmp;
  always #5 clk = ~clk;
  ws2812_frame_ctrl #(.NUM_LEDS(N), .FRAME_CYCLES(FC), .LATCH_CYCLES(LC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_rgb(wr_rgb), .commit(commit), .commit_pending(commit_pending),
    .frame_start(frame_start), .drv_reset(drv_reset), .drv_address(drv_address),
    .drv_new_address(drv_new_address), .red_out(red_out), .green_out(green_out), .blue_out(blue_out)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // age = cycles since the last LATCH entry, -1 while idle; banks swap as whole arrays
  always @(posedge clk or posedge reset)
    if (reset) begin
      age = -1;
      m_pend = 0;
      m_fs = 0;
      m_rgb = 0;
      for (int i = 0; i < N; i++) begin
        m_front[i] = 0;
        m_back[i] = 0;
      end
    end else begin
      enter = enable && (age < 0 || age == FC - 1);
      m_fs = enter;
      if (wr_valid && !m_pend && int'(wr_addr) < N) m_back[wr_addr] = wr_rgb;
      if (drv_new_address) m_rgb = int'(drv_address) < N ? m_front[drv_address] : 24'h0;
      if (enter && m_pend) begin
        for (int i = 0; i < N; i++) begin
          tmp = m_front[i];
          m_front[i] = m_back[i];
          m_back[i] = tmp;
        end
        m_pend = commit;
      end else m_pend = m_pend | commit;
      age = enter ? 0 : (age < 0 || age == FC - 1) ? -1 : age + 1;
    end
  always @(negedge clk)
    if (!reset) begin
      chk("m_drv_reset", drv_reset, age < LC);
      chk("m_frame_start", frame_start, m_fs);
      chk("m_commit_pending", commit_pending, m_pend);
      chk("m_wr_ready", wr_ready, !m_pend);
      chk("m_rgb", {red_out, green_out, blue_out}, m_rgb);
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_fs();
    int n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 500);
    chk("frame_start_wait", frame_start, 1);
  endtask
  task automatic write(input logic [2:0] a, input logic [23:0] d);
    wr_addr = a;
    wr_rgb = d;
    wr_valid = 1;
    step();
    wr_valid = 0;
  endtask
  task automatic strobe(input logic [2:0] a);
    drv_address = a;
    drv_new_address = 1;
    step();
    drv_new_address = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_drv_reset", drv_reset, 1);
    chk("rst_pending", commit_pending, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_rgb", {red_out, green_out, blue_out}, 0);
    reset = 0;
    step();
    chk("ready_after_rst", wr_ready, 1);
    enable = 1;
    wait_fs();
    n_hi = 0;
    for (int i = 0; i < FC; i++) begin
      n_hi += int'(drv_reset);
      step();
    end
    chk("frame_period", frame_start, 1);
    chk("latch_len", n_hi, LC);
    write(3, 24'h00FF00);
    repeat (3) wait_fs();
    strobe(3);
    chk("no_commit_rd3", {red_out, green_out, blue_out}, 24'h000000);
    repeat (30) step();
    write(3, 24'hFF0000);
    commit = 1;
    step();
    commit = 0;
    chk("commit_pending_set", commit_pending, 1);
    chk("wr_ready_blocked", wr_ready, 0);
    wait_fs();
    chk("swap_clears_pending", commit_pending, 0);
    strobe(3);
    chk("swap_rd3", {red_out, green_out, blue_out}, 24'hFF0000);
    wait_fs();
    wr_addr = 2;
    wr_rgb = 24'h0000FF;
    wr_valid = 1;
    commit = 1;
    step();
    wr_valid = 0;
    commit = 0;
    chk("wr_commit_same_cycle", commit_pending, 1);
    repeat (198) step();
    commit = 1;
    step();
    commit = 0;
    chk("commit_at_entry_fs", frame_start, 1);
    chk("commit_at_entry_pend", commit_pending, 1);
    strobe(2);
    chk("first_swap_rd2", {red_out, green_out, blue_out}, 24'h0000FF);
    strobe(3);
    chk("new_back_old_front", {red_out, green_out, blue_out}, 24'h000000);
    strobe(2);
    wait_fs();
    chk("second_swap_pend", commit_pending, 0);
    chk("swap_holds_rgb", {red_out, green_out, blue_out}, 24'h0000FF);
    strobe(2);
    chk("second_swap_rd2", {red_out, green_out, blue_out}, 24'h000000);
    strobe(3);
    chk("second_swap_rd3", {red_out, green_out, blue_out}, 24'hFF0000);
    write(7, 24'hABCDEF);
    strobe(7);
    chk("oob_read", {red_out, green_out, blue_out}, 24'h000000);
    wait_fs();
    repeat (70) step();
    enable = 0;
    repeat (129) step();
    chk("run_not_shortened", drv_reset, 0);
    step();
    chk("hold_drv_reset", drv_reset, 1);
    chk("hold_no_fs", frame_start, 0);
    n_fs = 0;
    repeat (300) begin
      step();
      n_fs += int'(frame_start);
    end
    chk("hold_fs_count", n_fs, 0);
    chk("hold_drv_reset_late", drv_reset, 1);
    enable = 1;
    wait_fs();
    strobe(3);
    chk("pre_reset_rd3", {red_out, green_out, blue_out}, 24'hFF0000);
    repeat (50) step();
    commit = 1;
    step();
    commit = 0;
    chk("pre_reset_pend", commit_pending, 1);
    #2 reset = 1;
    #1;
    chk("async_drv_reset", drv_reset, 1);
    chk("async_pending", commit_pending, 0);
    chk("async_rgb", {red_out, green_out, blue_out}, 0);
    chk("async_fs", frame_start, 0);
    @(posedge clk);
    #1 reset = 0;
    step();
    strobe(3);
    chk("post_reset_rd3", {red_out, green_out, blue_out}, 0);
    strobe(2);
    chk("post_reset_rd2", {red_out, green_out, blue_out}, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
